// File: rtl/router_data_reg.sv
// Router datapath register stage: header latch, FIFO write-data steering with a
// one-byte hold for FIFO-full stalls, and running XOR parity check per packet.
module router_data_reg #(
  parameter int         DATA_W   = 8,
  parameter logic [1:0] BAD_ADDR = 2'b11
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] hdr_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] int_par;
  logic [DATA_W-1:0] pkt_par;

  function automatic logic addr_ok(input logic [DATA_W-1:0] b);
    return b[1:0] != BAD_ADDR;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hdr_reg       <= '0;
      hold_reg      <= '0;
      int_par       <= '0;
      pkt_par       <= '0;
      dout          <= '0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
      err           <= 1'b0;
    end else if (detect_add) begin
      parity_done <= 1'b0;
      pkt_par     <= '0;
      if (pkt_valid && addr_ok(data_in)) begin
        hdr_reg <= data_in;
        int_par <= '0;
      end
    end else if (lfd_state) begin
      // err stays visible until the next packet's header is written out.
      dout    <= hdr_reg;
      int_par <= hdr_reg;
      err     <= 1'b0;
    end else if (ld_state) begin
      if (pkt_valid) begin
        int_par <= int_par ^ data_in;
        if (fifo_full)
          hold_reg <= data_in;
        else
          dout <= data_in;
      end else begin
        // pkt_valid low marks the trailing parity byte; it is not folded into int_par.
        pkt_par       <= data_in;
        low_pkt_valid <= 1'b1;
        if (fifo_full) begin
          hold_reg <= data_in;
        end else begin
          dout        <= data_in;
          parity_done <= 1'b1;
        end
      end
    end else if (laf_state) begin
      dout <= hold_reg;
      if (low_pkt_valid && !parity_done)
        parity_done <= 1'b1;
    end else if (full_state) begin
      // Source is stalled; every register holds.
    end else if (rst_int_reg) begin
      err           <= (int_par != pkt_par);
      low_pkt_valid <= 1'b0;
    end
  end

endmodule
